adpll_gain_sched: RTL

- Gain-scheduling and lock-supervision controller for the ring ADPLL.
- Drives the loop enable and the kp/ki gain inputs: high acquisition gains until lock, then low tracking gains.
- Declares lock and loss of lock from the phase-error stream.
- Restarts the loop if acquisition times out.
- Sits between the top level (switches or fixed constants) and the ADPLL, in the fast fpga clock domain.

---
 rtl/adpll_gain_sched_if.sv | 30 +++
 rtl/adpll_gain_sched.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/adpll_gain_sched_if.sv
// Control and gain bus between the top level, the gain scheduler and the ADPLL.
// The slave modport is the scheduler's view; master is the driving side.
interface adpll_gain_sched_if #(
  parameter int ERR_WIDTH  = 8,
  parameter int GAIN_WIDTH = 8
);
  logic                        enable_i;
  logic                        ref_clk_i;
  logic signed [ERR_WIDTH-1:0] error_i;
  logic [GAIN_WIDTH-1:0]       kp_acq_i;
  logic [GAIN_WIDTH-1:0]       ki_acq_i;
  logic [GAIN_WIDTH-1:0]       kp_trk_i;
  logic [GAIN_WIDTH-1:0]       ki_trk_i;
  logic                        adpll_enable_o;
  logic [GAIN_WIDTH-1:0]       kp_o;
  logic [GAIN_WIDTH-1:0]       ki_o;
  logic                        locked_o;
  logic [1:0]                  state_o;
  logic [7:0]                  restart_cnt_o;

  modport master (
    output enable_i, ref_clk_i, error_i, kp_acq_i, ki_acq_i, kp_trk_i, ki_trk_i,
    input  adpll_enable_o, kp_o, ki_o, locked_o, state_o, restart_cnt_o
  );

  modport slave (
    input  enable_i, ref_clk_i, error_i, kp_acq_i, ki_acq_i, kp_trk_i, ki_trk_i,
    output adpll_enable_o, kp_o, ki_o, locked_o, state_o, restart_cnt_o
  );
endinterface

// File: rtl/adpll_gain_sched.sv
// ADPLL gain scheduler and lock supervisor: acquisition/tracking gain selection,
// lock/unlock detection on reference-edge samples and timeout-driven loop restart.
module adpll_gain_sched #(
  parameter int ERR_WIDTH      = 8,
  parameter int GAIN_WIDTH     = 8,
  parameter int CNT_WIDTH      = 16,
  parameter int LOCK_THRESH    = 2,
  parameter int UNLOCK_THRESH  = 8,
  parameter int LOCK_COUNT     = 64,
  parameter int UNLOCK_COUNT   = 4,
  parameter int ACQ_TIMEOUT    = 4096,
  parameter int RESTART_CYCLES = 256
) (
  input  logic              fpga_clk_i,
  input  logic              reset_i,
  adpll_gain_sched_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACQ  = 2'd1;
  localparam logic [1:0] S_TRK  = 2'd2;
  localparam logic [1:0] S_RST  = 2'd3;

  localparam logic [ERR_WIDTH:0]   LOCK_T    = (ERR_WIDTH+1)'(LOCK_THRESH);
  localparam logic [ERR_WIDTH:0]   UNLOCK_T  = (ERR_WIDTH+1)'(UNLOCK_THRESH);
  localparam logic [CNT_WIDTH-1:0] LOCK_N    = CNT_WIDTH'(LOCK_COUNT);
  localparam logic [CNT_WIDTH-1:0] UNLOCK_N  = CNT_WIDTH'(UNLOCK_COUNT);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_N = CNT_WIDTH'(ACQ_TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] RESTART_N = CNT_WIDTH'(RESTART_CYCLES);

  // One extra bit so the most negative error has a representable magnitude.
  function automatic logic [ERR_WIDTH:0] abs_err(input logic signed [ERR_WIDTH-1:0] e);
    logic signed [ERR_WIDTH:0] ext;
    ext = {e[ERR_WIDTH-1], e};
    abs_err = (ext < 0) ? $unsigned(-ext) : $unsigned(ext);
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    sat_inc = (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] c);
    sat_inc8 = (&c) ? c : c + 8'd1;
  endfunction

  logic [1:0]            state, state_n;
  logic                  ref_q;
  logic [CNT_WIDTH-1:0]  lock_cnt, lock_n, to_cnt, to_n, unl_cnt, unl_n, rs_cnt, rs_n;
  logic [7:0]            rcnt, rcnt_n;
  logic                  samp, in_lock, out_lock;
  logic [ERR_WIDTH:0]    mag;
  logic                  en_n, locked_n;
  logic [GAIN_WIDTH-1:0] kp_n, ki_n;

  always_comb begin
    samp     = bus.ref_clk_i & ~ref_q;
    mag      = abs_err(bus.error_i);
    in_lock  = (mag <= LOCK_T);
    out_lock = (mag > UNLOCK_T);
    state_n  = state;
    lock_n   = lock_cnt;
    to_n     = to_cnt;
    unl_n    = unl_cnt;
    rs_n     = rs_cnt;
    rcnt_n   = rcnt;
    if (!bus.enable_i) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          state_n = S_ACQ;
          lock_n  = '0;
          to_n    = '0;
          unl_n   = '0;
          rs_n    = '0;
          rcnt_n  = '0;
        end
        S_ACQ: if (samp) begin
          to_n   = sat_inc(to_cnt);
          lock_n = in_lock ? sat_inc(lock_cnt) : '0;
          // Lock is tested first so it wins a tie with the timeout.
          if (lock_n >= LOCK_N) begin
            state_n = S_TRK;
            unl_n   = '0;
          end else if (to_n >= TIMEOUT_N) begin
            state_n = S_RST;
            rs_n    = '0;
            rcnt_n  = sat_inc8(rcnt);
          end
        end
        S_TRK: if (samp) begin
          unl_n = out_lock ? sat_inc(unl_cnt) : '0;
          if (unl_n >= UNLOCK_N) begin
            state_n = S_ACQ;
            lock_n  = '0;
            to_n    = '0;
            unl_n   = '0;
          end
        end
        default: begin
          rs_n = sat_inc(rs_cnt);
          if (rs_n >= RESTART_N) begin
            state_n = S_ACQ;
            lock_n  = '0;
            to_n    = '0;
            unl_n   = '0;
            rs_n    = '0;
          end
        end
      endcase
    end

    // Outputs decoded from the next state so they register with the state itself.
    en_n     = (state_n == S_ACQ) || (state_n == S_TRK);
    locked_n = (state_n == S_TRK);
    kp_n     = '0;
    ki_n     = '0;
    if (state_n == S_TRK) begin
      kp_n = bus.kp_trk_i;
      ki_n = bus.ki_trk_i;
    end else if (state_n != S_IDLE) begin
      kp_n = bus.kp_acq_i;
      ki_n = bus.ki_acq_i;
    end
  end

  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state              <= S_IDLE;
      ref_q              <= 1'b0;
      lock_cnt           <= '0;
      to_cnt             <= '0;
      unl_cnt            <= '0;
      rs_cnt             <= '0;
      rcnt               <= '0;
      bus.adpll_enable_o <= 1'b0;
      bus.kp_o           <= '0;
      bus.ki_o           <= '0;
      bus.locked_o       <= 1'b0;
    end else begin
      state              <= state_n;
      ref_q              <= bus.ref_clk_i;
      lock_cnt           <= lock_n;
      to_cnt             <= to_n;
      unl_cnt            <= unl_n;
      rs_cnt             <= rs_n;
      rcnt               <= rcnt_n;
      bus.adpll_enable_o <= en_n;
      bus.kp_o           <= kp_n;
      bus.ki_o           <= ki_n;
      bus.locked_o       <= locked_n;
    end
  end

  assign bus.state_o       = state;
  assign bus.restart_cnt_o = rcnt;

endmodule
